// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory: load/store opcodes,
// FSM state encoding, access-size encoding and the opcode decoder.
package dmem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    typedef struct packed {
        logic  req;
        logic  store;
        logic  sign;
        size_t size;
    } dec_t;

    function automatic dec_t decode_op(input logic [5:0] op);
        dec_t d;
        d.req   = 1'b1;
        d.store = 1'b0;
        d.sign  = 1'b0;
        d.size  = SZ_WORD;
        case (op)
            OP_LB:  begin d.size = SZ_BYTE; d.sign = 1'b1; end
            OP_LH:  begin d.size = SZ_HALF; d.sign = 1'b1; end
            OP_LW:  d.size = SZ_WORD;
            OP_LBU: d.size = SZ_BYTE;
            OP_LHU: d.size = SZ_HALF;
            OP_SB:  begin d.size = SZ_BYTE; d.store = 1'b1; end
            OP_SH:  begin d.size = SZ_HALF; d.store = 1'b1; end
            OP_SW:  begin d.size = SZ_WORD; d.store = 1'b1; end
            default: d.req = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian byte-lane steering: load extraction/extension, store
// read-modify-write merge, and alignment checking.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  offset_i,
    input  size_t       size_i,
    input  logic        sign_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o,
    output logic        misalign_o
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] base_mask;
    logic [31:0] mask;

    always_comb begin
        shamt      = {offset_i, 3'b000};
        shifted    = word_i >> shamt;
        misalign_o = ((size_i == SZ_HALF) && offset_i[0]) ||
                     ((size_i == SZ_WORD) && (offset_i != 2'b00));

        case (size_i)
            SZ_BYTE: begin
                load_o    = {{24{sign_i & shifted[7]}}, shifted[7:0]};
                base_mask = 32'h0000_00FF;
            end
            SZ_HALF: begin
                load_o    = {{16{sign_i & shifted[15]}}, shifted[15:0]};
                base_mask = 32'h0000_FFFF;
            end
            default: begin
                load_o    = shifted;
                base_mask = 32'hFFFF_FFFF;
            end
        endcase

        // Untouched lanes keep the old word's bytes.
        mask    = base_mask << shamt;
        store_o = (word_i & ~mask) | ((wdata_i << shamt) & mask);
    end

endmodule

// File: rtl/mem_stage_dmem.sv
// MEM-stage data memory: decodes the EX/MEM opcode, holds the pipeline with
// stall for WAIT_CYCLES cycles, then completes the load or store.
module mem_stage_dmem
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output state_t      dbg_state_o,
    output logic [3:0]  dbg_cnt_o
);

    localparam int         IDX_W   = $clog2(DEPTH);
    localparam logic [3:0] WAIT_M1 = 4'(WAIT_CYCLES - 1);

    logic [31:0] mem_q [DEPTH];

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    dec_t             dec;
    logic [IDX_W-1:0] idx;
    logic [31:0]      cur_word;
    logic [31:0]      load_word;
    logic [31:0]      merged_word;
    logic             mis_raw;
    logic             aligned_req;
    logic             complete;
    logic             stall_raw;
    logic             unused_addr_bits;

    assign dec              = decode_op(opcode);
    assign idx              = addr[IDX_W+1:2];
    assign cur_word         = mem_q[idx];
    assign aligned_req      = dec.req && !mis_raw;
    assign unused_addr_bits = ^addr[31:IDX_W+2];

    dmem_lane_align u_align (
        .word_i     (cur_word),
        .wdata_i    (wdata),
        .offset_i   (addr[1:0]),
        .size_i     (dec.size),
        .sign_i     (dec.sign),
        .load_o     (load_word),
        .store_o    (merged_word),
        .misalign_o (mis_raw)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        complete  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (aligned_req) begin
                    if (WAIT_CYCLES == 0) begin
                        complete = 1'b1;
                    end else begin
                        stall_raw = 1'b1;
                        if (WAIT_CYCLES == 1) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_BUSY;
                            cnt_d   = WAIT_M1;
                        end
                    end
                end
            end
            ST_BUSY: begin
                stall_raw = 1'b1;
                cnt_d     = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Inputs are held through the stall, so the request is still present.
                complete = aligned_req;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are forced quiet during reset regardless of stale state.
        complete = complete && rst_n;
        stall    = stall_raw && rst_n;
        misalign = rst_n && dec.req && mis_raw && (state_q == ST_IDLE);
        rdata    = (complete && !dec.store) ? load_word : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (complete && dec.store) begin
            mem_q[idx] <= merged_word;
        end
    end

    assign dbg_state_o = state_q;
    assign dbg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_mem_stage_dmem.sv
// Bench for mem_stage_dmem: three instances (WAIT_CYCLES 0, 2, 3) exercised by a
// vector table on the zero-wait instance plus directed multi-cycle sequences.
module tb_mem_stage_dmem;

    localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24;
    localparam logic [5:0] LHU = 6'h25, SB = 6'h28, SH = 6'h29, SW = 6'h2B;
    localparam int D0 = 0, D2 = 1, D3 = 2;

    logic        clk;
    logic        rstn [3];
    logic [5:0]  op   [3];
    logic [31:0] ad   [3];
    logic [31:0] wd   [3];
    logic [31:0] rd   [3];
    logic        st   [3];
    logic        mis  [3];
    logic [1:0]  dst  [3];
    logic [3:0]  dcnt [3];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_stage_dmem #(.DEPTH(1024), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst_n(rstn[0]), .opcode(op[0]), .addr(ad[0]), .wdata(wd[0]),
        .rdata(rd[0]), .stall(st[0]), .misalign(mis[0]),
        .dbg_state_o(dst[0]), .dbg_cnt_o(dcnt[0])
    );
    mem_stage_dmem #(.DEPTH(1024), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst_n(rstn[1]), .opcode(op[1]), .addr(ad[1]), .wdata(wd[1]),
        .rdata(rd[1]), .stall(st[1]), .misalign(mis[1]),
        .dbg_state_o(dst[1]), .dbg_cnt_o(dcnt[1])
    );
    mem_stage_dmem #(.DEPTH(1024), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst_n(rstn[2]), .opcode(op[2]), .addr(ad[2]), .wdata(wd[2]),
        .rdata(rd[2]), .stall(st[2]), .misalign(mis[2]),
        .dbg_state_o(dst[2]), .dbg_cnt_o(dcnt[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic [5:0] o, input logic [31:0] a, input logic [31:0] w,
                           input logic [31:0] e, input logic m);
        vec_t v;
        v.op = o; v.addr = a; v.wdata = w; v.exp_rd = e; v.exp_mis = m;
        vecs.push_back(v);
    endtask

    task automatic drive(input int d, input logic [5:0] o, input logic [31:0] a, input logic [31:0] w);
        @(posedge clk); #1;
        op[d] = o; ad[d] = a; wd[d] = w;
    endtask

    // Holds the request through `waits` stall cycles, then checks completion.
    task automatic access(input int d, input string name, input logic [5:0] o, input logic [31:0] a,
                          input logic [31:0] w, input int waits, input logic [31:0] exp_rd);
        drive(d, o, a, w);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check({name, "_stall"}, {31'd0, st[d]}, 32'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check({name, "_done_stall"}, {31'd0, st[d]}, 32'd0);
        check({name, "_rdata"}, rd[d], exp_rd);
        check({name, "_mis"}, {31'd0, mis[d]}, 32'd0);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rstn[d] = 1'b0; op[d] = 6'h00; ad[d] = 32'd0; wd[d] = 32'd0;
        end
        // Requests presented during reset must be suppressed.
        op[0] = LW; op[1] = SW; op[2] = SW;
        @(posedge clk); #1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_stall", {31'd0, st[d]}, 32'd0);
            check("rst_rdata", rd[d], 32'd0);
            check("rst_mis", {31'd0, mis[d]}, 32'd0);
        end
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            rstn[d] = 1'b1; op[d] = 6'h00;
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_state", {30'd0, dst[d]}, 32'd0);
            check("rst_cnt", {28'd0, dcnt[d]}, 32'd0);
        end

        // Zero-wait instance: one access per cycle.
        add_vec(SW,  32'h20, 32'h0000_0000, 32'h0, 1'b0);
        add_vec(SB,  32'h21, 32'h0000_0080, 32'h0, 1'b0);
        add_vec(LW,  32'h20, 32'h0, 32'h0000_8000, 1'b0);
        add_vec(LB,  32'h21, 32'h0, 32'hFFFF_FF80, 1'b0);
        add_vec(LBU, 32'h21, 32'h0, 32'h0000_0080, 1'b0);
        add_vec(SW,  32'h30, 32'h0000_0000, 32'h0, 1'b0);
        add_vec(SH,  32'h32, 32'h0000_8001, 32'h0, 1'b0);
        add_vec(LH,  32'h32, 32'h0, 32'hFFFF_8001, 1'b0);
        add_vec(LHU, 32'h32, 32'h0, 32'h0000_8001, 1'b0);
        add_vec(LH,  32'h33, 32'h0, 32'h0, 1'b1);
        add_vec(LW,  32'h30, 32'h0, 32'h8001_0000, 1'b0);
        add_vec(SH,  32'h33, 32'h0000_BEEF, 32'h0, 1'b1);
        add_vec(SW,  32'h32, 32'hCAFE_F00D, 32'h0, 1'b1);
        add_vec(LW,  32'h30, 32'h0, 32'h8001_0000, 1'b0);
        add_vec(SW,  32'h1000, 32'h1234_5678, 32'h0, 1'b0);
        add_vec(LW,  32'h0, 32'h0, 32'h1234_5678, 1'b0);
        add_vec(LW,  32'h22, 32'h0, 32'h0, 1'b1);
        add_vec(6'h00, 32'h30, 32'hFFFF_FFFF, 32'h0, 1'b0);
        add_vec(SB,  32'h23, 32'h0000_007F, 32'h0, 1'b0);
        add_vec(LW,  32'h20, 32'h0, 32'h7F00_8000, 1'b0);
        add_vec(LH,  32'h20, 32'h0, 32'hFFFF_8000, 1'b0);
        add_vec(LHU, 32'h22, 32'h0, 32'h0000_7F00, 1'b0);
        add_vec(LB,  32'h23, 32'h0, 32'h0000_007F, 1'b0);
        add_vec(LW,  32'h30, 32'h0, 32'h8001_0000, 1'b0);

        foreach (vecs[i]) begin
            drive(D0, vecs[i].op, vecs[i].addr, vecs[i].wdata);
            @(negedge clk);
            check($sformatf("vec%0d_rdata", i), rd[0], vecs[i].exp_rd);
            check($sformatf("vec%0d_mis", i), {31'd0, mis[0]}, {31'd0, vecs[i].exp_mis});
            check($sformatf("vec%0d_stall", i), {31'd0, st[0]}, 32'd0);
        end
        drive(D0, 6'h00, 32'h0, 32'h0);

        // Two-wait instance: word round trip and back-to-back timing.
        access(D2, "w2_sw", SW, 32'h10, 32'hDEAD_BEEF, 2, 32'h0);
        access(D2, "w2_lw", LW, 32'h10, 32'h0, 2, 32'hDEAD_BEEF);
        access(D2, "w2_sb", SB, 32'h12, 32'h0000_0011, 2, 32'h0);
        access(D2, "w2_lw2", LW, 32'h10, 32'h0, 2, 32'hDE11_BEEF);

        // Misaligned access: flagged immediately, never stalls.
        drive(D2, LW, 32'h11, 32'h0);
        @(negedge clk);
        check("w2_mis_flag", {31'd0, mis[1]}, 32'd1);
        check("w2_mis_stall", {31'd0, st[1]}, 32'd0);
        check("w2_mis_rdata", rd[1], 32'd0);
        drive(D2, 6'h00, 32'h0, 32'h0);
        @(negedge clk);
        check("w2_mis_state", {30'd0, dst[1]}, 32'd0);

        // Non-memory opcode for five cycles.
        for (int i = 0; i < 5; i++) begin
            drive(D2, 6'h00, 32'h10 + 32'(i), 32'hFFFF_FFFF);
            @(negedge clk);
            check("nop_stall", {31'd0, st[1]}, 32'd0);
            check("nop_rdata", rd[1], 32'd0);
            check("nop_mis", {31'd0, mis[1]}, 32'd0);
        end

        // Three-wait instance: reset during BUSY drops the pending store.
        access(D3, "w3_init", SW, 32'h40, 32'h1122_3344, 3, 32'h0);
        drive(D3, SW, 32'h40, 32'hFFFF_FFFF);
        @(negedge clk);
        check("w3_req_stall", {31'd0, st[2]}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("w3_busy_state", {30'd0, dst[2]}, 32'd1);
        check("w3_busy_cnt", {28'd0, dcnt[2]}, 32'd2);
        @(posedge clk); #1;
        rstn[2] = 1'b0;
        @(negedge clk);
        check("w3_rst_stall", {31'd0, st[2]}, 32'd0);
        @(posedge clk); #1;
        rstn[2] = 1'b1;
        op[2] = 6'h00;
        @(negedge clk);
        check("w3_post_state", {30'd0, dst[2]}, 32'd0);
        check("w3_post_cnt", {28'd0, dcnt[2]}, 32'd0);
        check("w3_post_stall", {31'd0, st[2]}, 32'd0);
        access(D3, "w3_lw", LW, 32'h40, 32'h0, 3, 32'h1122_3344);
        drive(D3, 6'h00, 32'h0, 32'h0);

        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
